// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, funct3 encodings and alignment helper for the
// memory port arbiter.
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    ERR   = 3'd4
  } resp_tag_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Store encodings alias the load ones, so matching the load codes covers both.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_LW:         return (addr_lo != 2'b00);
      F3_LH, F3_LHU: return addr_lo[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts data grants taken while a fetch waits and
// forces a fetch grant once the limit is reached.
`default_nettype none

module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic force_fetch
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_fetch = if_req && (starve_cnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the memory read port and funct3 between fetch and
// load/store, tracks the one-cycle read latency and returns tagged responses.
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  resp_tag_t   tag_q, tag_d;
  logic [31:0] raddr_q;
  logic        force_fetch;
  logic        misaligned;
  logic        load_go;
  logic        store_go;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt),
    .force_fetch(force_fetch)
  );

  // Grants are masked while reset is held so the memory sees an idle port.
  assign d_gnt      = rst_n && d_req && !force_fetch;
  assign if_gnt     = rst_n && if_req && !d_gnt;
  assign misaligned = is_misaligned(d_funct3, d_addr[1:0]);
  assign load_go    = d_gnt && !d_we && !misaligned;
  assign store_go   = d_gnt && d_we && !misaligned;

  always_comb begin
    mem_write  = 1'b0;
    mem_funct3 = F3_LW;
    mem_waddr  = 32'd0;
    mem_wdata  = 32'd0;
    mem_raddr  = raddr_q;
    tag_d      = NONE;
    if (if_gnt) begin
      mem_raddr = if_addr;
      tag_d     = FETCH;
    end else if (d_gnt) begin
      if (misaligned) begin
        tag_d = ERR;
      end else if (store_go) begin
        mem_write  = 1'b1;
        mem_funct3 = d_funct3;
        mem_waddr  = d_addr;
        mem_wdata  = d_wdata;
        tag_d      = STORE;
      end else if (load_go) begin
        mem_funct3 = d_funct3;
        mem_raddr  = d_addr;
        tag_d      = LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= NONE;
      raddr_q <= 32'd0;
    end else begin
      tag_q   <= tag_d;
      raddr_q <= mem_raddr;
    end
  end

  // Read data flows straight from memory in the cycle after the grant.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    case (tag_q)
      FETCH: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      LOAD: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      STORE: d_rvalid = 1'b1;
      ERR: begin
        d_rvalid = 1'b1;
        d_err    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter against a small
// byte-lane memory model with one-cycle read latency.
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_funct3  (d_funct3),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_write (mem_write),
    .mem_funct3(mem_funct3),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  // Byte-lane memory: writes commit at the edge, reads register address/funct3.
  logic [7:0]  mem [0:511];
  logic [8:0]  ra;
  logic [2:0]  rf3;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_waddr[8:0]] <= mem_wdata[7:0];
      if (mem_funct3 != 3'b000) mem[mem_waddr[8:0] + 9'd1] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[mem_waddr[8:0] + 9'd2] <= mem_wdata[23:16];
        mem[mem_waddr[8:0] + 9'd3] <= mem_wdata[31:24];
      end
    end
    ra  <= mem_raddr[8:0];
    rf3 <= mem_funct3;
  end

  always_comb begin
    mem_rdata = 32'd0;
    case (rf3)
      3'b000: mem_rdata = {{24{mem[ra][7]}}, mem[ra]};
      3'b001: mem_rdata = {{16{mem[ra+9'd1][7]}}, mem[ra+9'd1], mem[ra]};
      3'b100: mem_rdata = {24'd0, mem[ra]};
      3'b101: mem_rdata = {16'd0, mem[ra+9'd1], mem[ra]};
      default: mem_rdata = {mem[ra+9'd3], mem[ra+9'd2], mem[ra+9'd1], mem[ra]};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    d_req = req; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
  endtask

  logic [7:0] fetch_slot;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    {mem[19], mem[18], mem[17], mem[16]} = 32'hDEADBEEF;
    {mem[67], mem[66], mem[65], mem[64]} = 32'h0BADF00D;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);

    // Reset state
    #3;
    check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    check("rst_d_err", {31'd0, d_err}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_funct3", {29'd0, mem_funct3}, 32'd2);
    check("rst_raddr", mem_raddr, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Fetch only, three back-to-back cycles
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("f_gnt0", {31'd0, if_gnt}, 32'd1);
    check("f_raddr", mem_raddr, 32'h10);
    check("f_funct3", {29'd0, mem_funct3}, 32'd2);
    check("f_rvalid0", {31'd0, if_rvalid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check("f_gnt", {31'd0, if_gnt}, 32'd1);
      check("f_rvalid", {31'd0, if_rvalid}, 32'd1);
      check("f_rdata", if_rdata, 32'hDEADBEEF);
    end
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    check("f_gnt_off", {31'd0, if_gnt}, 32'd0);
    check("f_rvalid_last", {31'd0, if_rvalid}, 32'd1);
    check("f_rdata_last", if_rdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("f_rvalid_end", {31'd0, if_rvalid}, 32'd0);
    check("f_raddr_hold", mem_raddr, 32'h10);

    // SB then LB, LBU from the same byte
    next_cycle();
    set_d(1'b1, 1'b1, 3'b000, 32'h101, 32'h000000A5);
    @(negedge clk);
    check("sb_gnt", {31'd0, d_gnt}, 32'd1);
    check("sb_write", {31'd0, mem_write}, 32'd1);
    check("sb_funct3", {29'd0, mem_funct3}, 32'd0);
    check("sb_waddr", mem_waddr, 32'h101);
    check("sb_wdata", mem_wdata, 32'hA5);
    next_cycle();
    set_d(1'b1, 1'b0, 3'b000, 32'h101, 32'd0);
    @(negedge clk);
    check("sb_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("sb_rdata", d_rdata, 32'd0);
    check("lb_write", {31'd0, mem_write}, 32'd0);
    check("lb_raddr", mem_raddr, 32'h101);
    next_cycle();
    set_d(1'b1, 1'b0, 3'b100, 32'h101, 32'd0);
    @(negedge clk);
    check("lb_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("lb_rdata", d_rdata, 32'hFFFFFFA5);
    next_cycle();
    set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    @(negedge clk);
    check("lbu_rdata", d_rdata, 32'h000000A5);
    check("idle_funct3", {29'd0, mem_funct3}, 32'd2);

    // Contention: expected grant order D,D,D,D,F,D,D,D
    fetch_slot = 8'b0001_0000;
    next_cycle();
    if_req = 1'b1; if_addr = 32'h10;
    set_d(1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("c_if_gnt", {31'd0, if_gnt}, {31'd0, fetch_slot[i]});
      check("c_d_gnt", {31'd0, d_gnt}, {31'd0, ~fetch_slot[i]});
      if (i > 0) begin
        check("c_if_rvalid", {31'd0, if_rvalid}, {31'd0, fetch_slot[i-1]});
        check("c_d_rvalid", {31'd0, d_rvalid}, {31'd0, ~fetch_slot[i-1]});
        if (fetch_slot[i-1]) check("c_if_rdata", if_rdata, 32'hDEADBEEF);
        else check("c_d_rdata", d_rdata, 32'h0BADF00D);
      end
      next_cycle();
    end
    if_req = 1'b0;
    set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    @(negedge clk);
    check("c_last_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("c_last_rdata", d_rdata, 32'h0BADF00D);

    // Misaligned LW and LH
    next_cycle();
    set_d(1'b1, 1'b0, 3'b010, 32'h102, 32'd0);
    @(negedge clk);
    check("mis_lw_gnt", {31'd0, d_gnt}, 32'd1);
    check("mis_lw_write", {31'd0, mem_write}, 32'd0);
    next_cycle();
    set_d(1'b1, 1'b0, 3'b001, 32'h103, 32'd0);
    @(negedge clk);
    check("mis_lw_resp", {29'd0, d_rvalid, d_err, 1'b0}, 32'd6);
    check("mis_lw_rdata", d_rdata, 32'd0);
    check("mis_lh_gnt", {31'd0, d_gnt}, 32'd1);
    check("mis_lh_write", {31'd0, mem_write}, 32'd0);
    next_cycle();
    set_d(1'b1, 1'b1, 3'b001, 32'h102, 32'h1234);
    @(negedge clk);
    check("mis_lh_resp", {29'd0, d_rvalid, d_err, 1'b0}, 32'd6);
    check("mis_lh_rdata", d_rdata, 32'd0);
    check("sh_aligned_err", {31'd0, d_err}, 32'd1);
    next_cycle();
    set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    @(negedge clk);
    check("sh_ok_resp", {29'd0, d_rvalid, d_err, 1'b0}, 32'd4);

    // Reset while a load is in flight
    next_cycle();
    set_d(1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
    @(negedge clk);
    check("rf_gnt", {31'd0, d_gnt}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rf_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("rf_funct3", {29'd0, mem_funct3}, 32'd2);
    check("rf_raddr", mem_raddr, 32'd0);
    next_cycle();
    check("rf_rvalid_in_rst", {31'd0, d_rvalid}, 32'd0);
    set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rf_no_rvalid", {31'd0, d_rvalid}, 32'd0);
      next_cycle();
    end

    // SW then LW of the same word in consecutive cycles
    set_d(1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678);
    @(negedge clk);
    check("sw_write", {31'd0, mem_write}, 32'd1);
    next_cycle();
    set_d(1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
    @(negedge clk);
    check("sw_resp", {31'd0, d_rvalid}, 32'd1);
    check("lw_gnt", {31'd0, d_gnt}, 32'd1);
    next_cycle();
    set_d(1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    @(negedge clk);
    check("lw_rdata", d_rdata, 32'h12345678);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
